// File: rtl/multicycle_controller.sv
// Multi-cycle core sequencer: steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives all datapath enables.
// Latency: ALU 4 cycles, branch/nop 3, store 4, load 5 (zero-wait memory); memory waits add cycles, MEM_TIMEOUT waits end in FAULT.
// Backpressure: req/ack to instruction and data memory; a raised request holds until ack. Optional counters: MULTICYCLE_PERF_COUNTER_EN.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        haltReq,
  input  logic        dcIsLoadInsn,
  input  logic        dcIsStoreInsn,
  input  logic        dcRfWrEnable,
  output logic        imemReq,
  input  logic        imemAck,
  output logic        dmemReq,
  input  logic        dmemAck,
  output logic        dataWrEnable,
  output logic        irWrEnable,
  output logic        opWrEnable,
  output logic        aluWrEnable,
  output logic        mdrWrEnable,
  output logic        rfWrEnable,
  output logic        pcWrEnable,
  output logic        insnRetired,
  output logic        halted,
  output logic        fault,
  output logic [31:0] cycleCount,
  output logic [31:0] retireCount
);

  localparam int CntWidth = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntWidth-1:0] LastWait = CntWidth'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    RESET_WAIT, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALTED, FAULT
  } ctrlState;

  ctrlState              state;
  ctrlState              nextState;
  ctrlState              afterRetire;
  logic [CntWidth-1:0]   waitCnt;
  logic                  isLoad;
  logic                  isStore;
  logic                  retire;
  logic                  waitExpired;

  // Next-state decode; a load+store combination is handled as a load.
  always_comb begin
    isLoad      = dcIsLoadInsn;
    isStore     = dcIsStoreInsn & ~dcIsLoadInsn;
    waitExpired = (waitCnt == LastWait);
    retire      = ((state == EXECUTE) & ~isLoad & ~isStore & ~dcRfWrEnable)
                | ((state == MEM) & dmemAck & isStore)
                | (state == WRITEBACK);
    afterRetire = haltReq ? HALTED : FETCH;
    nextState   = state;
    case (state)
      RESET_WAIT: nextState = haltReq ? HALTED : FETCH;
      FETCH: begin
        if (imemAck)          nextState = DECODE;
        else if (waitExpired) nextState = FAULT;
      end
      DECODE:  nextState = EXECUTE;
      EXECUTE: begin
        if (isLoad || isStore) nextState = MEM;
        else if (dcRfWrEnable) nextState = WRITEBACK;
        else                   nextState = afterRetire;
      end
      MEM: begin
        if (dmemAck)          nextState = isLoad ? WRITEBACK : afterRetire;
        else if (waitExpired) nextState = FAULT;
      end
      WRITEBACK: nextState = afterRetire;
      HALTED:    nextState = haltReq ? HALTED : FETCH;
      FAULT:     nextState = FAULT;
      default:   nextState = FAULT;
    endcase
  end

  // State, wait counter and state-only (Moore) outputs, registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RESET_WAIT;
      waitCnt     <= '0;
      imemReq     <= 1'b0;
      dmemReq     <= 1'b0;
      opWrEnable  <= 1'b0;
      aluWrEnable <= 1'b0;
      rfWrEnable  <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state <= nextState;
      // Counter restarts on every entry to FETCH or MEM and counts cycles spent waiting there.
      if ((state == FETCH || state == MEM) && nextState == state)
        waitCnt <= waitCnt + CntWidth'(1);
      else
        waitCnt <= '0;
      imemReq     <= (nextState == FETCH);
      dmemReq     <= (nextState == MEM);
      opWrEnable  <= (nextState == DECODE);
      aluWrEnable <= (nextState == EXECUTE);
      rfWrEnable  <= (nextState == WRITEBACK);
      halted      <= (nextState == HALTED);
      fault       <= (nextState == FAULT);
    end
  end

  // Ack-qualified strobes act in the ack cycle itself, gated by the current state so reset drops them at once.
  assign irWrEnable   = (state == FETCH) & imemAck;
  assign mdrWrEnable  = (state == MEM) & dmemAck & isLoad;
  assign dataWrEnable = (state == MEM) & isStore;
  assign pcWrEnable   = retire;
  assign insnRetired  = retire;

`ifdef MULTICYCLE_PERF_COUNTER_EN
  // Free-running 32-bit performance counters; wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycleCount  <= '0;
      retireCount <= '0;
    end else begin
      if (state != RESET_WAIT && state != HALTED && state != FAULT)
        cycleCount <= cycleCount + 32'd1;
      if (retire)
        retireCount <= retireCount + 32'd1;
    end
  end
`else
  assign cycleCount  = '0;
  assign retireCount = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected output vectors for each instruction class.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// Built with MEM_TIMEOUT=4 so the fault path is reachable in a few cycles.
module tb_multicycle_controller;

  logic        clk;
  logic        rst;
  logic        haltReq, dcIsLoadInsn, dcIsStoreInsn, dcRfWrEnable, imemAck, dmemAck;
  logic        imemReq, dmemReq, dataWrEnable, irWrEnable, opWrEnable, aluWrEnable;
  logic        mdrWrEnable, rfWrEnable, pcWrEnable, insnRetired, halted, fault;
  logic [31:0] cycleCount, retireCount;
  logic [11:0] outs;

  int checks   = 0;
  int failures = 0;

  localparam logic [11:0] O_IREQ = 12'h800, O_DREQ = 12'h400, O_DWR = 12'h200, O_IR  = 12'h100;
  localparam logic [11:0] O_OP   = 12'h080, O_ALU  = 12'h040, O_MDR = 12'h020, O_RF  = 12'h010;
  localparam logic [11:0] O_PC   = 12'h008, O_RET  = 12'h004, O_HLT = 12'h002, O_FLT = 12'h001;
  localparam logic [11:0] O_NONE = 12'h000;

`ifdef MULTICYCLE_PERF_COUNTER_EN
  localparam logic [31:0] ExpRetire = 32'd10, ExpCycles = 32'd40;
`else
  localparam logic [31:0] ExpRetire = 32'd0, ExpCycles = 32'd0;
`endif

  multicycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .haltReq(haltReq),
    .dcIsLoadInsn(dcIsLoadInsn), .dcIsStoreInsn(dcIsStoreInsn), .dcRfWrEnable(dcRfWrEnable),
    .imemReq(imemReq), .imemAck(imemAck), .dmemReq(dmemReq), .dmemAck(dmemAck),
    .dataWrEnable(dataWrEnable), .irWrEnable(irWrEnable), .opWrEnable(opWrEnable),
    .aluWrEnable(aluWrEnable), .mdrWrEnable(mdrWrEnable), .rfWrEnable(rfWrEnable),
    .pcWrEnable(pcWrEnable), .insnRetired(insnRetired), .halted(halted), .fault(fault),
    .cycleCount(cycleCount), .retireCount(retireCount)
  );

  assign outs = {imemReq, dmemReq, dataWrEnable, irWrEnable, opWrEnable, aluWrEnable,
                 mdrWrEnable, rfWrEnable, pcWrEnable, insnRetired, halted, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setIn(input logic h, input logic ld, input logic st, input logic rfw,
                       input logic ia, input logic da);
    haltReq = h; dcIsLoadInsn = ld; dcIsStoreInsn = st; dcRfWrEnable = rfw;
    imemAck = ia; dmemAck = da;
  endtask

  // Holds reset for two edges and releases it just after a rising edge (start of the RESET_WAIT cycle).
  task automatic applyReset();
    rst = 1'b0;
    setIn(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    setIn(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (outs !== O_NONE) begin failures++; $display("FAIL reset_outs: got %h expected %h", outs, O_NONE); end
    checks++;
    if (cycleCount !== 32'd0 || retireCount !== 32'd0) begin
      failures++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycleCount, retireCount);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== O_NONE) begin failures++; $display("FAIL reset_release: got %h expected %h", outs, O_NONE); end
  endtask

  task automatic test_alu();
    logic [11:0] exp [4] = '{O_IREQ | O_IR, O_OP, O_ALU, O_RF | O_PC | O_RET};
    applyReset();
    setIn(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (outs !== exp[i % 4]) begin
        failures++; $display("FAIL alu cycle %0d: got %h expected %h", i + 1, outs, exp[i % 4]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (retireCount !== ExpRetire) begin
      failures++; $display("FAIL alu_retireCount: got %0d expected %0d", retireCount, ExpRetire);
    end
    checks++;
    if (cycleCount !== ExpCycles) begin
      failures++; $display("FAIL alu_cycleCount: got %0d expected %0d", cycleCount, ExpCycles);
    end
  endtask

  task automatic test_branch();
    logic [11:0] exp [4] = '{O_IREQ | O_IR, O_OP, O_ALU | O_PC | O_RET, O_IREQ | O_IR};
    applyReset();
    setIn(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        failures++; $display("FAIL branch cycle %0d: got %h expected %h", i + 1, outs, exp[i]);
      end
    end
  endtask

  task automatic test_load();
    logic [11:0] exp [9] = '{O_IREQ | O_IR, O_OP, O_ALU, O_DREQ, O_DREQ, O_DREQ,
                             O_DREQ | O_MDR, O_RF | O_PC | O_RET, O_IREQ | O_IR};
    applyReset();
    setIn(0, 1, 0, 1, 1, 0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      dmemAck = (i == 6);
      @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        failures++; $display("FAIL load cycle %0d: got %h expected %h", i + 1, outs, exp[i]);
      end
    end
  endtask

  task automatic test_load_store_both();
    logic [11:0] exp [5] = '{O_IREQ | O_IR, O_OP, O_ALU, O_DREQ | O_MDR, O_RF | O_PC | O_RET};
    applyReset();
    setIn(0, 1, 1, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        failures++; $display("FAIL ldst_both cycle %0d: got %h expected %h", i + 1, outs, exp[i]);
      end
    end
  endtask

  task automatic test_store();
    logic [11:0] exp [5] = '{O_IREQ | O_IR, O_OP, O_ALU, O_DREQ | O_DWR | O_PC | O_RET, O_IREQ | O_IR};
    applyReset();
    setIn(0, 0, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        failures++; $display("FAIL store cycle %0d: got %h expected %h", i + 1, outs, exp[i]);
      end
    end
  endtask

  task automatic test_halt_during_store();
    logic [11:0] exp [8] = '{O_IREQ | O_IR, O_OP, O_ALU, O_DREQ | O_DWR,
                             O_DREQ | O_DWR | O_PC | O_RET, O_HLT, O_HLT, O_IREQ | O_IR};
    applyReset();
    setIn(0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      dmemAck = (i == 4);
      haltReq = (i >= 3 && i <= 5);
      @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        failures++; $display("FAIL halt cycle %0d: got %h expected %h", i + 1, outs, exp[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [11:0] exp [8] = '{O_IREQ, O_IREQ, O_IREQ, O_IREQ, O_FLT, O_FLT, O_FLT, O_FLT};
    applyReset();
    setIn(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      imemAck = (i >= 5);
      dmemAck = (i >= 5);
      haltReq = (i == 6);
      @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        failures++; $display("FAIL timeout cycle %0d: got %h expected %h", i + 1, outs, exp[i]);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== O_NONE) begin failures++; $display("FAIL timeout_reset: got %h expected %h", outs, O_NONE); end
    applyReset();
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (outs !== O_IREQ) begin failures++; $display("FAIL timeout_refetch: got %h expected %h", outs, O_IREQ); end
  endtask

  task automatic test_reset_in_wb();
    logic [11:0] exp [4] = '{O_IREQ | O_IR, O_OP, O_ALU, O_RF | O_PC | O_RET};
    applyReset();
    setIn(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        failures++; $display("FAIL rstwb cycle %0d: got %h expected %h", i + 1, outs, exp[i]);
      end
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (outs !== O_NONE) begin failures++; $display("FAIL rstwb_async_drop: got %h expected %h", outs, O_NONE); end
    applyReset();
    setIn(0, 0, 0, 1, 1, 0);
    @(negedge clk);
    checks++;
    if (outs !== O_NONE) begin failures++; $display("FAIL rstwb_wait_cycle: got %h expected %h", outs, O_NONE); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (outs !== (O_IREQ | O_IR)) begin
      failures++; $display("FAIL rstwb_first_fetch: got %h expected %h", outs, O_IREQ | O_IR);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_load();
    test_load_store_both();
    test_store();
    test_halt_during_store();
    test_timeout();
    test_reset_in_wb();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
